// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin hold arbiter.
// Supports up to MAX_CLIENTS requesters.
package arb_pkg;

    localparam int MAX_CLIENTS = 32;
    localparam int MAX_ID_W    = $clog2(MAX_CLIENTS);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // One-hot (or zero) to binary index; a zero vector yields index 0.
    function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_CLIENTS-1:0] oh);
        logic [MAX_ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CLIENTS; i++) begin
            if (oh[i]) idx = idx | MAX_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first candidate at or after start_i,
// wrapping, using a doubled request vector.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     excl_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     gnt_o,
    output logic             found_o
);

    logic [N-1:0]   cand;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   low;

    assign cand = req_i & ~excl_i;
    assign dbl  = {cand, cand};

    // rot[0] is the candidate at start_i; isolate its lowest set bit, then rotate back.
    assign rot     = dbl[start_i +: N];
    assign low     = rot & (~rot + 1'b1);
    assign gnt_o   = N'(({low, low} << start_i) >> N);
    assign found_o = |cand;

endmodule

// File: rtl/wrr_hold_arbiter.sv
// Round-robin arbiter with grant hold and per-client time quantum (weight).
// Ownership is preempted with zero bubble when the quantum expires under contention.
module wrr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int WEIGHT_W    = 4,
    parameter int ID_W        = $clog2(NUM_CLIENTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CLIENTS-1:0]          req,
    input  logic [NUM_CLIENTS*WEIGHT_W-1:0] weight,
    output logic [NUM_CLIENTS-1:0]          grant,
    output logic                            grant_valid,
    output logic [ID_W-1:0]                 grant_id,
    output logic                            preempt
);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic                   valid_q, valid_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic                   preempt_q, preempt_d;

    logic [NUM_CLIENTS-1:0] pick_gnt;
    logic                   pick_found;
    logic [ID_W-1:0]        pick_id;
    logic [WEIGHT_W-1:0]    owner_weight;
    logic                   owner_req;
    logic                   expired;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
        return (32'(i) == NUM_CLIENTS - 1) ? '0 : i + 1'b1;
    endfunction

    // ptr_q is kept at owner+1 while OWNED, so one picker serves both states;
    // excluding grant_q is a no-op in IDLE because grant_q is zero there.
    rr_pick #(
        .N     (NUM_CLIENTS),
        .IDX_W (ID_W)
    ) u_pick (
        .req_i   (req),
        .excl_i  (grant_q),
        .start_i (ptr_q),
        .gnt_o   (pick_gnt),
        .found_o (pick_found)
    );

    assign pick_id      = ID_W'(onehot_to_idx(MAX_CLIENTS'(pick_gnt)));
    assign owner_weight = weight[id_q*WEIGHT_W +: WEIGHT_W];
    assign owner_req    = |(req & grant_q);
    assign expired      = (owner_weight != '0) && (cnt_q >= owner_weight);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        id_d      = id_q;
        preempt_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWNED;
                    grant_d = pick_gnt;
                    valid_d = 1'b1;
                    id_d    = pick_id;
                    ptr_d   = next_idx(pick_id);
                    cnt_d   = WEIGHT_W'(1);
                end
            end
            OWNED: begin
                if (!owner_req || (expired && pick_found)) begin
                    if (pick_found) begin
                        grant_d   = pick_gnt;
                        id_d      = pick_id;
                        ptr_d     = next_idx(pick_id);
                        cnt_d     = WEIGHT_W'(1);
                        preempt_d = owner_req;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                        id_d    = '0;
                        cnt_d   = '0;
                    end
                end else if (expired) begin
                    cnt_d = WEIGHT_W'(1);
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_wrr_hold_arbiter.sv
// Directed self-checking bench for wrr_hold_arbiter (N=4, WEIGHT_W=4).
module tb_wrr_hold_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*WW-1:0] weight;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [1:0]    grant_id;
    logic          preempt;

    int n_checks = 0;
    int n_pass   = 0;

    wrr_hold_arbiter #(
        .NUM_CLIENTS (N),
        .WEIGHT_W    (WW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .weight      (weight),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .preempt     (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        weight = '0;
        #3;
        check("rst_grant",   32'(grant), 32'h0);
        check("rst_valid",   32'(grant_valid), 32'h0);
        check("rst_id",      32'(grant_id), 32'h0);
        check("rst_preempt", 32'(preempt), 32'h0);
        step();
        rst = 1'b0;

        // Lone requester, unlimited weight: granted after one edge and held.
        req = 4'b0100;
        step();
        check("lone_grant", 32'(grant), 32'h4);
        check("lone_id",    32'(grant_id), 32'h2);
        check("lone_valid", 32'(grant_valid), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("lone_hold",    32'(grant), 32'h4);
            check("lone_nopre",   32'(preempt), 32'h0);
        end
        req = '0;
        step();
        check("lone_release", 32'(grant), 32'h0);
        check("lone_rel_val", 32'(grant_valid), 32'h0);

        // Full contention, all weights 2: each client holds exactly two cycles.
        do_reset();
        weight = 16'h2222;
        req    = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("rr_grant",   32'(grant), 32'(1 << (((k - 1) / 2) % 4)));
            check("rr_id",      32'(grant_id), 32'(((k - 1) / 2) % 4));
            check("rr_preempt", 32'(preempt), 32'((k >= 3) && (k % 2 == 1)));
        end

        // Release hand-off: no bubble, no preempt.
        do_reset();
        weight = '0;
        req    = 4'b1001;
        step();
        check("ho_first", 32'(grant), 32'h1);
        req = 4'b1000;
        step();
        check("ho_grant",   32'(grant), 32'h8);
        check("ho_valid",   32'(grant_valid), 32'h1);
        check("ho_preempt", 32'(preempt), 32'h0);

        // Unlimited hold under contention, then release.
        do_reset();
        weight = '0;
        req    = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            step();
            check("unl_hold", 32'(grant), 32'h1);
        end
        req = 4'b0010;
        step();
        check("unl_handoff", 32'(grant), 32'h2);
        check("unl_preempt", 32'(preempt), 32'h0);

        // Quantum expiry with no contender: grant stays, never preempts.
        do_reset();
        weight = 16'h0003;
        req    = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            check("qnc_grant",   32'(grant), 32'h1);
            check("qnc_preempt", 32'(preempt), 32'h0);
        end

        // Simultaneous release and expiry counts as release.
        do_reset();
        weight = 16'h2222;
        req    = 4'b0011;
        step();
        step();
        check("sim_pre", 32'(grant), 32'h1);
        req = 4'b0010;
        step();
        check("sim_grant",   32'(grant), 32'h2);
        check("sim_preempt", 32'(preempt), 32'h0);

        // Weight lowered below the running counter expires on the next edge.
        do_reset();
        weight = '0;
        req    = 4'b0011;
        for (int i = 0; i < 5; i++) step();
        check("wl_hold", 32'(grant), 32'h1);
        weight = 16'h0002;
        step();
        check("wl_grant",   32'(grant), 32'h2);
        check("wl_preempt", 32'(preempt), 32'h1);
        step();
        check("wl_pulse",   32'(preempt), 32'h0);

        // Asynchronous reset mid-tenure, then restart from index 0.
        do_reset();
        weight = '0;
        req    = 4'b0100;
        step();
        step();
        check("ar_owner", 32'(grant), 32'h4);
        #3;
        rst = 1'b1;
        #1;
        check("ar_grant", 32'(grant), 32'h0);
        check("ar_valid", 32'(grant_valid), 32'h0);
        check("ar_id",    32'(grant_id), 32'h0);
        step();
        rst = 1'b0;
        req = 4'b1010;
        step();
        check("ar_restart",    32'(grant), 32'h2);
        check("ar_restart_id", 32'(grant_id), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wrr_hold_arbiter.md
Name: wrr_hold_arbiter

Overview:
- Parametrised round-robin arbiter with grant hold and a per-client time quantum.
- The grant stays on the owning client while its req stays high, up to a programmable number of cycles (its weight).
- If other clients are waiting when the quantum expires, the grant is preempted and passed on with zero bubble.
- Sits in front of shared resources (bus port, memory bank) where masters hold ownership across multi-cycle bursts.

Parameters:
- NUM_CLIENTS, 4, number of requesters (>=2).
- WEIGHT_W, 4, width of each per-client quantum field and of the tenure counter.
- ID_W, $clog2(NUM_CLIENTS), width of grant_id (derived; not overridden).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_CLIENTS  per-client request, level; held high for the whole desired tenure.
- weight  input  NUM_CLIENTS*WEIGHT_W  per-client quantum in cycles; client i uses bits [i*WEIGHT_W +: WEIGHT_W]; 0 = unlimited hold; quasi-static, sampled every cycle.
- grant  output  NUM_CLIENTS  registered one-hot grant, or all-zero.
- grant_valid  output  1  registered; equals |grant.
- grant_id  output  ID_W  registered binary index of the owner; 0 when grant_valid=0.
- preempt  output  1  registered one-cycle pulse when ownership moved because a quantum expired.

Behaviour:
- Reset (async, rst=1):
  - grant=0, grant_valid=0, grant_id=0, preempt=0.
  - State=IDLE, search pointer=0, tenure counter=0.
- State IDLE (no owner):
  - If |req, the winner is the first set req bit at or after the pointer, wrapping modulo NUM_CLIENTS.
  - The winner's grant is asserted on the next edge (req-to-grant latency 1 cycle).
  - Go to OWNED; counter=1.
- State OWNED (owner k):
  - Each cycle, evaluate in this priority order:
  - a) Release: req[k]=0.
    - Next owner = first requester after k, excluding k, wrapping.
    - If one exists: grant moves to it next edge (zero-bubble hand-off), counter=1, preempt=0.
    - Otherwise: grant=0 next edge, go to IDLE, pointer=k+1 mod N.
  - b) Expiry: weight[k]!=0, counter>=weight[k], and some other req bit set.
    - Grant moves to the first other requester after k next edge, preempt=1 for that cycle, counter=1.
    - Owner k therefore holds exactly weight[k] cycles under contention.
  - c) Expiry with no other requester: owner keeps the grant, counter restarts at 1, no preempt.
  - d) Otherwise: hold the grant; counter increments, saturating at all-ones.
- Simultaneous release and expiry is treated as release: preempt=0.
- Weight lowered mid-tenure below the current counter: expires on the next evaluation (>= compare).
- Pointer is always owner+1 after any hand-off or release, which gives fairness across rotations.
- The owner sees grant high for one cycle after it drops req (registered grant). Clients must treat grant as qualified by their own req.
- Reset mid-tenure: outputs clear immediately, asynchronously. After release, arbitration restarts from index 0.
- Invariants:
  - grant is always one-hot or zero.
  - grant_id matches grant.
  - preempt=1 only in a cycle where grant changed between two non-zero values.

Decomposition:
- Package arb_pkg: clog2-derived width constants, state enum (IDLE, OWNED), and a function for one-hot-to-index conversion.
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: req vector, exclude mask, start index.
  - Outputs: one-hot winner and found flag.
  - Implemented with a doubled request vector.
- The top level holds the state, pointer, counter and output registers.

Test Plan:
- Configuration for all scenarios: N=4, WEIGHT_W=4.
- Lone requester: req=0100, weights=0 → grant=0100, grant_id=2 from cycle 1, held indefinitely, preempt never.
- Full contention: req=1111 constant, all weights=2 → grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001…; preempt=1 on each change.
- Release hand-off: owner 0, req goes 1001→1000 → next cycle grant=1000, no all-zero cycle, preempt=0.
- Unlimited hold: weight[0]=0, req=0011 for 20 cycles → grant=0001 throughout; on req[0] drop → grant=0010 next cycle.
- Quantum without contender: req=0001, weight[0]=3, 10 cycles → grant continuously 0001, preempt never set.
- Async reset mid-tenure: owner 2, rst pulsed mid-cycle → grant=0 before next edge. With req=1010 after release → first grant=0010.
